param_reservation_station: RTL and testbench
============================================

PARAM_RESERVATION_STATION -- requirements
Module: param_reservation_station

Interface
REQ-001 SHALL have parameter RS_SIZE, default 16, meaning number of entries (power of two, 4..64).
REQ-002 SHALL have parameter DATA_W, default 32, meaning operand, immediate and PC width.
REQ-003 SHALL have parameter ROB_W, default 4, meaning reorder-buffer tag width.
REQ-004 SHALL have parameter TYPE_W, default 6, meaning instruction-type width.
REQ-005 SHALL have parameter N_BYPASS, default 2, meaning number of result-broadcast channels.
REQ-006 SHALL have port clk_in, input, 1, the single clock.
REQ-007 SHALL have port rst_in, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port rdy_in, input, 1; when low, all state and outputs hold.
REQ-009 SHALL have port flush_in, input, 1, mispredict flush.
REQ-010 SHALL have port rs_full, output, 1, high when no entry is free.
REQ-011 SHALL have port alloc_enable, input, 1, allocation request.
REQ-012 SHALL have ports alloc_vj, alloc_vk (DATA_W), alloc_qj, alloc_qk (ROB_W), alloc_rdy1, alloc_rdy2 (1), alloc_imm, alloc_pc (DATA_W), alloc_type (TYPE_W), alloc_dest (ROB_W), all inputs.
REQ-013 SHALL have ports byp_enable (N_BYPASS), byp_tag (N_BYPASS*ROB_W) and byp_value (N_BYPASS*DATA_W), inputs; channel k occupies slice k.
REQ-014 SHALL have port alu_ready_in, input, 1, downstream can accept an issue.
REQ-015 SHALL have ports rs2alu_enable (1), rs2alu_rs1, rs2alu_rs2, rs2alu_imm, rs2alu_pc (DATA_W), rs2alu_ins_type (TYPE_W) and rs2alu_reorder (ROB_W), all registered outputs.

Function
REQ-016 SHALL drive rs_full combinationally as the AND of all busy bits; an allocation while full is dropped, even if an issue frees an entry on the same edge.
REQ-017 SHALL write an accepted allocation into the lowest-index free entry at the clock edge and set its busy bit.
REQ-018 SHALL, for an allocating operand whose ready flag is low and whose tag matches an enabled bypass channel in the same cycle, store the bypass value with ready set.
REQ-019 SHALL, each edge, set ready and capture the value for every busy entry operand that is not ready and whose tag matches an enabled channel; on multiple matches the lowest channel wins.
REQ-020 SHALL make an entry issue-eligible when it is busy and both operands are ready at the start of the cycle; an entry woken at edge N is eligible in cycle N+1.
REQ-021 SHALL, when alu_ready_in is high and at least one entry is eligible, select the lowest-index eligible entry, register its fields to rs2alu_*, pulse rs2alu_enable for one cycle and clear busy on the same edge.
REQ-022 SHALL deassert rs2alu_enable on any edge with no issue; rs2alu_* data holds its last value.
REQ-023 SHALL make an entry freed by issue allocatable from the next cycle.
REQ-024 SHALL, when flush_in is high at an edge, clear all busy bits and rs2alu_enable, overriding allocation, issue and wakeup.
REQ-025 SHALL, when rdy_in is low, ignore alloc_enable, bypass inputs and flush_in.

Reset
REQ-026 SHALL on rst_in assertion asynchronously clear all busy bits and ready flags, set rs2alu_enable to 0 and set all rs2alu_* data outputs to 0; rs_full is then 0.

Structure
REQ-027 SHALL place the entry field layout, tag type and default widths in the shared CPU package.
REQ-028 SHALL instantiate one sub-module, rs_select, as a parametrised lowest-index priority encoder with a valid flag, used twice (free select and ready select).

Verification
REQ-029 SHALL cover: 16 allocations with both operands ready and alu_ready_in low -> rs_full high after the 16th; a 17th allocation is dropped.
REQ-030 SHALL cover: allocate with qj=3, rdy1=0 while channel 1 broadcasts tag 3, value 0x55 in the same cycle -> the entry issues the next cycle with rs2alu_rs1=0x55.
REQ-031 SHALL cover: entries 0, 2 and 5 eligible with alu_ready_in high -> issue order is 0, 2, 5 on consecutive cycles, each with a single-cycle enable.
REQ-032 SHALL cover: both channels broadcast tag 7 with values 0x11 and 0x22 -> a waiting operand captures 0x11.
REQ-033 SHALL cover: flush_in with 6 busy entries and an allocation pending -> the next cycle has 0 busy entries, rs2alu_enable is 0 and rs_full is 0.
REQ-034 SHALL cover: rst_in asserted mid-issue between clock edges -> rs2alu_enable drops immediately and all outputs are 0.

Source files
------------

// File: rtl/param_reservation_station_pkg.sv
// Shared CPU package: default widths, the ROB tag type and the
// reservation-station entry layout used by the issue-queue logic.
package param_reservation_station_pkg;

  localparam int DEF_RS_SIZE  = 16;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ROB_W    = 4;
  localparam int DEF_TYPE_W   = 6;
  localparam int DEF_N_BYPASS = 2;

  typedef logic [DEF_ROB_W-1:0] rob_tag_t;

  // One station entry at the default configuration. Parametrised instances
  // keep the same field order, split into per-field arrays.
  typedef struct packed {
    logic                  busy;
    logic                  rdy1;
    logic                  rdy2;
    logic [DEF_DATA_W-1:0] vj;
    logic [DEF_DATA_W-1:0] vk;
    rob_tag_t              qj;
    rob_tag_t              qk;
    logic [DEF_DATA_W-1:0] imm;
    logic [DEF_DATA_W-1:0] pc;
    logic [DEF_TYPE_W-1:0] insType;
    rob_tag_t              dest;
  } rs_entry_t;

  // Index width for an N-entry structure; never below one bit.
  function automatic int rs_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/param_reservation_station_rs_select.sv
// Lowest-index priority encoder with a valid flag. Used both to find the
// first free entry and to pick the first issue-eligible entry.
module rs_select #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Scan from the top down so the lowest set request is the last one written.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = IDX_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/param_reservation_station.sv
// Reservation station: holds instructions until both operands are ready,
// snoops result broadcasts for wakeup and issues the lowest ready entry.
module param_reservation_station
  import param_reservation_station_pkg::*;
#(
  parameter int RS_SIZE  = DEF_RS_SIZE,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ROB_W    = DEF_ROB_W,
  parameter int TYPE_W   = DEF_TYPE_W,
  parameter int N_BYPASS = DEF_N_BYPASS
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       flush_in,
  output logic                       rs_full,
  input  logic                       alloc_enable,
  input  logic [DATA_W-1:0]          alloc_vj,
  input  logic [DATA_W-1:0]          alloc_vk,
  input  logic [ROB_W-1:0]           alloc_qj,
  input  logic [ROB_W-1:0]           alloc_qk,
  input  logic                       alloc_rdy1,
  input  logic                       alloc_rdy2,
  input  logic [DATA_W-1:0]          alloc_imm,
  input  logic [DATA_W-1:0]          alloc_pc,
  input  logic [TYPE_W-1:0]          alloc_type,
  input  logic [ROB_W-1:0]           alloc_dest,
  input  logic [N_BYPASS-1:0]        byp_enable,
  input  logic [N_BYPASS*ROB_W-1:0]  byp_tag,
  input  logic [N_BYPASS*DATA_W-1:0] byp_value,
  input  logic                       alu_ready_in,
  output logic                       rs2alu_enable,
  output logic [DATA_W-1:0]          rs2alu_rs1,
  output logic [DATA_W-1:0]          rs2alu_rs2,
  output logic [DATA_W-1:0]          rs2alu_imm,
  output logic [DATA_W-1:0]          rs2alu_pc,
  output logic [TYPE_W-1:0]          rs2alu_ins_type,
  output logic [ROB_W-1:0]           rs2alu_reorder
);

  localparam int IDX_W = rs_idx_w(RS_SIZE);

  // Entry storage: control bits are reset, payload fields are not since
  // they are only ever read behind a set busy bit.
  logic [RS_SIZE-1:0] r_busy;
  logic [RS_SIZE-1:0] r_rdy1;
  logic [RS_SIZE-1:0] r_rdy2;
  logic [DATA_W-1:0]  r_vj   [RS_SIZE];
  logic [DATA_W-1:0]  r_vk   [RS_SIZE];
  logic [ROB_W-1:0]   r_qj   [RS_SIZE];
  logic [ROB_W-1:0]   r_qk   [RS_SIZE];
  logic [DATA_W-1:0]  r_imm  [RS_SIZE];
  logic [DATA_W-1:0]  r_pc   [RS_SIZE];
  logic [TYPE_W-1:0]  r_type [RS_SIZE];
  logic [ROB_W-1:0]   r_dest [RS_SIZE];

  logic [RS_SIZE-1:0] w_hit1;
  logic [RS_SIZE-1:0] w_hit2;
  logic [DATA_W-1:0]  w_wakeVal1 [RS_SIZE];
  logic [DATA_W-1:0]  w_wakeVal2 [RS_SIZE];
  logic               w_allocHit1;
  logic               w_allocHit2;
  logic [DATA_W-1:0]  w_allocVal1;
  logic [DATA_W-1:0]  w_allocVal2;

  logic [RS_SIZE-1:0] w_eligible;
  logic [IDX_W-1:0]   w_freeIdx;
  logic               w_freeValid;
  logic [IDX_W-1:0]   w_issueIdx;
  logic               w_issueValid;
  logic               w_doAlloc;
  logic               w_doIssue;

  // Search the broadcast channels for a tag; the lowest matching channel wins.
  // Returns {hit, value}.
  function automatic logic [DATA_W:0] bypassLookup(
    input logic [ROB_W-1:0]           tag,
    input logic [N_BYPASS-1:0]        en,
    input logic [N_BYPASS*ROB_W-1:0]  tags,
    input logic [N_BYPASS*DATA_W-1:0] vals
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int k = N_BYPASS - 1; k >= 0; k--) begin
      if (en[k] && (tags[k*ROB_W +: ROB_W] == tag)) begin
        res = {1'b1, vals[k*DATA_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  // Bypass matches for every stored operand and for the incoming allocation.
  always_comb begin
    w_hit1 = '0;
    w_hit2 = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      {w_hit1[i], w_wakeVal1[i]} = bypassLookup(r_qj[i], byp_enable, byp_tag, byp_value);
      {w_hit2[i], w_wakeVal2[i]} = bypassLookup(r_qk[i], byp_enable, byp_tag, byp_value);
    end
    {w_allocHit1, w_allocVal1} = bypassLookup(alloc_qj, byp_enable, byp_tag, byp_value);
    {w_allocHit2, w_allocVal2} = bypassLookup(alloc_qk, byp_enable, byp_tag, byp_value);
  end

  // Eligibility uses only registered state, so a wakeup lands one cycle
  // before the entry can be picked.
  assign w_eligible = r_busy & r_rdy1 & r_rdy2;
  assign rs_full    = &r_busy;

  rs_select #(
    .N     (RS_SIZE),
    .IDX_W (IDX_W)
  ) u_freeSel (
    .i_req   (~r_busy),
    .o_idx   (w_freeIdx),
    .o_valid (w_freeValid)
  );

  rs_select #(
    .N     (RS_SIZE),
    .IDX_W (IDX_W)
  ) u_readySel (
    .i_req   (w_eligible),
    .o_idx   (w_issueIdx),
    .o_valid (w_issueValid)
  );

  // Allocation looks at start-of-cycle occupancy, so a slot freed by a
  // same-edge issue cannot be reused until the following cycle.
  assign w_doAlloc = rdy_in && !flush_in && alloc_enable && w_freeValid;
  assign w_doIssue = rdy_in && !flush_in && alu_ready_in && w_issueValid;

  // Control state and registered issue port: flush wins over everything,
  // otherwise issue, wakeup and allocation update disjoint entries.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_busy          <= '0;
      r_rdy1          <= '0;
      r_rdy2          <= '0;
      rs2alu_enable   <= 1'b0;
      rs2alu_rs1      <= '0;
      rs2alu_rs2      <= '0;
      rs2alu_imm      <= '0;
      rs2alu_pc       <= '0;
      rs2alu_ins_type <= '0;
      rs2alu_reorder  <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        r_busy        <= '0;
        rs2alu_enable <= 1'b0;
      end else begin
        rs2alu_enable <= w_doIssue;
        for (int i = 0; i < RS_SIZE; i++) begin
          if (r_busy[i] && !r_rdy1[i] && w_hit1[i]) begin
            r_rdy1[i] <= 1'b1;
          end
          if (r_busy[i] && !r_rdy2[i] && w_hit2[i]) begin
            r_rdy2[i] <= 1'b1;
          end
        end
        if (w_doIssue) begin
          r_busy[w_issueIdx] <= 1'b0;
          rs2alu_rs1         <= r_vj[w_issueIdx];
          rs2alu_rs2         <= r_vk[w_issueIdx];
          rs2alu_imm         <= r_imm[w_issueIdx];
          rs2alu_pc          <= r_pc[w_issueIdx];
          rs2alu_ins_type    <= r_type[w_issueIdx];
          rs2alu_reorder     <= r_dest[w_issueIdx];
        end
        if (w_doAlloc) begin
          r_busy[w_freeIdx] <= 1'b1;
          r_rdy1[w_freeIdx] <= alloc_rdy1 | w_allocHit1;
          r_rdy2[w_freeIdx] <= alloc_rdy2 | w_allocHit2;
        end
      end
    end
  end

  // Entry payload: captured on allocation (with same-cycle bypass) and
  // overwritten by broadcast values when a waiting operand wakes.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i] && !r_rdy1[i] && w_hit1[i]) begin
          r_vj[i] <= w_wakeVal1[i];
        end
        if (r_busy[i] && !r_rdy2[i] && w_hit2[i]) begin
          r_vk[i] <= w_wakeVal2[i];
        end
      end
      if (w_doAlloc) begin
        r_vj[w_freeIdx]   <= (!alloc_rdy1 && w_allocHit1) ? w_allocVal1 : alloc_vj;
        r_vk[w_freeIdx]   <= (!alloc_rdy2 && w_allocHit2) ? w_allocVal2 : alloc_vk;
        r_qj[w_freeIdx]   <= alloc_qj;
        r_qk[w_freeIdx]   <= alloc_qk;
        r_imm[w_freeIdx]  <= alloc_imm;
        r_pc[w_freeIdx]   <= alloc_pc;
        r_type[w_freeIdx] <= alloc_type;
        r_dest[w_freeIdx] <= alloc_dest;
      end
    end
  end

endmodule

// File: tb/tb_param_reservation_station.sv
// Testbench for param_reservation_station: directed scenarios plus random
// traffic, checked through a scoreboard fed by a behavioural model.
module tb_param_reservation_station;

  localparam int NE = 16;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic        rs_full;
  logic        alloc_enable;
  logic [31:0] alloc_vj, alloc_vk, alloc_imm, alloc_pc;
  logic [3:0]  alloc_qj, alloc_qk, alloc_dest;
  logic        alloc_rdy1, alloc_rdy2;
  logic [5:0]  alloc_type;
  logic [1:0]  byp_enable;
  logic [7:0]  byp_tag;
  logic [63:0] byp_value;
  logic        alu_ready_in;
  logic        rs2alu_enable;
  logic [31:0] rs2alu_rs1, rs2alu_rs2, rs2alu_imm, rs2alu_pc;
  logic [5:0]  rs2alu_ins_type;
  logic [3:0]  rs2alu_reorder;

  typedef struct {
    logic        rdy, flush, alloc, r1, r2, alu;
    logic [31:0] vj, vk, imm, pc;
    logic [3:0]  qj, qk, dest;
    logic [5:0]  typ;
    logic [1:0]  bEn;
    logic [3:0]  bTag0, bTag1;
    logic [31:0] bVal0, bVal1;
  } stim_t;

  typedef struct {
    logic [31:0] rs1, rs2, imm, pc;
    logic [5:0]  typ;
    logic [3:0]  dest;
  } issue_t;

  int checks = 0;
  int failures = 0;
  issue_t expQ[$];

  // Reference model: one record per station slot plus the last issue
  // (the issue port repeats it while the pipeline is stalled).
  bit          mBusy[NE];
  bit          mR1[NE];
  bit          mR2[NE];
  logic [31:0] mVj[NE], mVk[NE], mImm[NE], mPc[NE];
  logic [3:0]  mQj[NE], mQk[NE], mDest[NE];
  logic [5:0]  mTyp[NE];
  bit          mLastValid;
  issue_t      mLast;

  param_reservation_station dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .flush_in        (flush_in),
    .rs_full         (rs_full),
    .alloc_enable    (alloc_enable),
    .alloc_vj        (alloc_vj),
    .alloc_vk        (alloc_vk),
    .alloc_qj        (alloc_qj),
    .alloc_qk        (alloc_qk),
    .alloc_rdy1      (alloc_rdy1),
    .alloc_rdy2      (alloc_rdy2),
    .alloc_imm       (alloc_imm),
    .alloc_pc        (alloc_pc),
    .alloc_type      (alloc_type),
    .alloc_dest      (alloc_dest),
    .byp_enable      (byp_enable),
    .byp_tag         (byp_tag),
    .byp_value       (byp_value),
    .alu_ready_in    (alu_ready_in),
    .rs2alu_enable   (rs2alu_enable),
    .rs2alu_rs1      (rs2alu_rs1),
    .rs2alu_rs2      (rs2alu_rs2),
    .rs2alu_imm      (rs2alu_imm),
    .rs2alu_pc       (rs2alu_pc),
    .rs2alu_ins_type (rs2alu_ins_type),
    .rs2alu_reorder  (rs2alu_reorder)
  );

  // Free-running 10-unit clock.
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic stim_t idleStim(input bit alu);
    stim_t s;
    s.rdy = 1'b1; s.flush = 1'b0; s.alloc = 1'b0; s.r1 = 1'b0; s.r2 = 1'b0; s.alu = alu;
    s.vj = '0; s.vk = '0; s.imm = '0; s.pc = '0;
    s.qj = '0; s.qk = '0; s.dest = '0; s.typ = '0;
    s.bEn = '0; s.bTag0 = '0; s.bTag1 = '0; s.bVal0 = '0; s.bVal1 = '0;
    return s;
  endfunction

  function automatic stim_t allocStim(input bit alu, input bit r1, input bit r2,
                                      input logic [3:0] qj, input logic [3:0] dest);
    stim_t s;
    s = idleStim(alu);
    s.alloc = 1'b1; s.r1 = r1; s.r2 = r2; s.qj = qj; s.qk = 4'($urandom_range(0, 15));
    s.vj = $urandom; s.vk = $urandom; s.imm = $urandom; s.pc = $urandom;
    s.typ = 6'($urandom); s.dest = dest;
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s = idleStim($urandom_range(0, 3) != 0);
    s.rdy   = ($urandom_range(0, 7) != 0);
    s.flush = ($urandom_range(0, 39) == 0);
    s.alloc = $urandom_range(0, 1);
    s.r1 = $urandom_range(0, 1); s.r2 = $urandom_range(0, 1);
    s.qj = 4'($urandom_range(0, 7)); s.qk = 4'($urandom_range(0, 7));
    s.vj = $urandom; s.vk = $urandom; s.imm = $urandom; s.pc = $urandom;
    s.typ = 6'($urandom); s.dest = 4'($urandom);
    s.bEn = 2'($urandom);
    s.bTag0 = 4'($urandom_range(0, 7)); s.bTag1 = 4'($urandom_range(0, 7));
    s.bVal0 = $urandom; s.bVal1 = $urandom;
    return s;
  endfunction

  // A tag is resolved by the first enabled channel carrying it.
  function automatic bit broadcastHit(input stim_t s, input logic [3:0] t, output logic [31:0] v);
    v = '0;
    if (s.bEn[0] && s.bTag0 == t) begin v = s.bVal0; return 1'b1; end
    if (s.bEn[1] && s.bTag1 == t) begin v = s.bVal1; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic bit modelFull();
    foreach (mBusy[i]) if (!mBusy[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelReset();
    foreach (mBusy[i]) begin mBusy[i] = 0; mR1[i] = 0; mR2[i] = 0; end
    mLastValid = 0;
    expQ.delete();
  endtask

  // Predict what the next clock edge does and queue any expected issue.
  task automatic modelStep(input stim_t s);
    int issued;
    int freeSlot;
    logic [31:0] v;
    issue_t rec;
    if (!s.rdy) begin
      if (mLastValid) expQ.push_back(mLast);
      return;
    end
    if (s.flush) begin
      foreach (mBusy[i]) mBusy[i] = 0;
      mLastValid = 0;
      return;
    end
    issued = -1;
    if (s.alu) begin
      for (int i = 0; i < NE; i++) begin
        if (mBusy[i] && mR1[i] && mR2[i]) begin issued = i; break; end
      end
    end
    if (issued >= 0) begin
      rec.rs1 = mVj[issued]; rec.rs2 = mVk[issued]; rec.imm = mImm[issued];
      rec.pc = mPc[issued]; rec.typ = mTyp[issued]; rec.dest = mDest[issued];
    end
    freeSlot = -1;
    if (s.alloc) begin
      for (int i = 0; i < NE; i++) begin
        if (!mBusy[i]) begin freeSlot = i; break; end
      end
    end
    for (int i = 0; i < NE; i++) begin
      if (mBusy[i] && !mR1[i] && broadcastHit(s, mQj[i], v)) begin mR1[i] = 1; mVj[i] = v; end
      if (mBusy[i] && !mR2[i] && broadcastHit(s, mQk[i], v)) begin mR2[i] = 1; mVk[i] = v; end
    end
    if (freeSlot >= 0) begin
      mBusy[freeSlot] = 1;
      mQj[freeSlot] = s.qj; mQk[freeSlot] = s.qk;
      mVj[freeSlot] = s.vj; mVk[freeSlot] = s.vk;
      mR1[freeSlot] = s.r1; mR2[freeSlot] = s.r2;
      if (!s.r1 && broadcastHit(s, s.qj, v)) begin mR1[freeSlot] = 1; mVj[freeSlot] = v; end
      if (!s.r2 && broadcastHit(s, s.qk, v)) begin mR2[freeSlot] = 1; mVk[freeSlot] = v; end
      mImm[freeSlot] = s.imm; mPc[freeSlot] = s.pc;
      mTyp[freeSlot] = s.typ; mDest[freeSlot] = s.dest;
    end
    if (issued >= 0) begin
      mBusy[issued] = 0;
      mLastValid = 1;
      mLast = rec;
      expQ.push_back(rec);
    end else begin
      mLastValid = 0;
    end
  endtask

  // Drive one cycle of stimulus, advance the model, then check occupancy.
  task automatic applyStimulus(input stim_t s, input string name);
    @(negedge clk_in);
    rdy_in = s.rdy; flush_in = s.flush; alloc_enable = s.alloc;
    alloc_vj = s.vj; alloc_vk = s.vk; alloc_qj = s.qj; alloc_qk = s.qk;
    alloc_rdy1 = s.r1; alloc_rdy2 = s.r2; alloc_imm = s.imm; alloc_pc = s.pc;
    alloc_type = s.typ; alloc_dest = s.dest;
    byp_enable = s.bEn; byp_tag = {s.bTag1, s.bTag0}; byp_value = {s.bVal1, s.bVal0};
    alu_ready_in = s.alu;
    modelStep(s);
    @(posedge clk_in);
    #2;
    checkOutput({name, "_full"}, 64'(rs_full), 64'(modelFull()));
  endtask

  // Monitor: every cycle the issue port fires, pop and compare one record.
  initial begin
    issue_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (!rst_in && rs2alu_enable) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_issue actual=enable(dest=%0h) expected=no issue", rs2alu_reorder);
        end else begin
          e = expQ.pop_front();
          checkOutput("issue_rs1", 64'(rs2alu_rs1), 64'(e.rs1));
          checkOutput("issue_rs2", 64'(rs2alu_rs2), 64'(e.rs2));
          checkOutput("issue_imm", 64'(rs2alu_imm), 64'(e.imm));
          checkOutput("issue_pc", 64'(rs2alu_pc), 64'(e.pc));
          checkOutput("issue_type", 64'(rs2alu_ins_type), 64'(e.typ));
          checkOutput("issue_dest", 64'(rs2alu_reorder), 64'(e.dest));
        end
      end
    end
  end

  // Main sequence: reset, directed scenarios, random traffic, reset mid-issue.
  initial begin
    stim_t s;
    rst_in = 1'b1;
    s = idleStim(1'b0);
    rdy_in = 1'b1; flush_in = 0; alloc_enable = 0; alloc_vj = 0; alloc_vk = 0;
    alloc_qj = 0; alloc_qk = 0; alloc_rdy1 = 0; alloc_rdy2 = 0; alloc_imm = 0;
    alloc_pc = 0; alloc_type = 0; alloc_dest = 0; byp_enable = 0; byp_tag = 0;
    byp_value = 0; alu_ready_in = 0;
    modelReset();
    #23;
    checkOutput("reset_enable", 64'(rs2alu_enable), 64'd0);
    checkOutput("reset_full", 64'(rs_full), 64'd0);
    checkOutput("reset_rs1", 64'(rs2alu_rs1), 64'd0);
    checkOutput("reset_reorder", 64'(rs2alu_reorder), 64'd0);
    @(negedge clk_in);
    rst_in = 1'b0;

    $display("[TB] fill to capacity, then one extra allocation");
    for (int i = 0; i < NE; i++) applyStimulus(allocStim(1'b0, 1'b1, 1'b1, 4'd0, 4'(i)), "fill");
    checkOutput("full_after_16", 64'(rs_full), 64'd1);
    applyStimulus(allocStim(1'b0, 1'b1, 1'b1, 4'd0, 4'd15), "alloc_17");
    for (int i = 0; i < NE + 2; i++) applyStimulus(idleStim(1'b1), "drain");

    $display("[TB] allocation with same-cycle bypass on channel 1");
    s = allocStim(1'b1, 1'b0, 1'b1, 4'd3, 4'd9);
    s.bEn = 2'b10; s.bTag1 = 4'd3; s.bVal1 = 32'h55;
    applyStimulus(s, "alloc_bypass");
    applyStimulus(idleStim(1'b1), "alloc_bypass_issue");
    applyStimulus(idleStim(1'b1), "alloc_bypass_idle");

    $display("[TB] issue order across eligible entries 0, 2, 5");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(allocStim(1'b0, (i == 0 || i == 2 || i == 5), 1'b1, 4'd12, 4'(i)), "order_alloc");
    end
    for (int i = 0; i < 5; i++) applyStimulus(idleStim(1'b1), "order_issue");
    s = idleStim(1'b1); s.flush = 1'b1;
    applyStimulus(s, "order_flush");

    $display("[TB] two channels broadcast the same tag");
    applyStimulus(allocStim(1'b0, 1'b0, 1'b1, 4'd7, 4'd4), "dual_alloc");
    s = idleStim(1'b1);
    s.bEn = 2'b11; s.bTag0 = 4'd7; s.bTag1 = 4'd7; s.bVal0 = 32'h11; s.bVal1 = 32'h22;
    applyStimulus(s, "dual_wake");
    for (int i = 0; i < 3; i++) applyStimulus(idleStim(1'b1), "dual_issue");

    $display("[TB] flush with six busy entries and an allocation pending");
    for (int i = 0; i < 6; i++) applyStimulus(allocStim(1'b0, 1'b1, 1'b1, 4'd0, 4'(i)), "flush_fill");
    s = allocStim(1'b1, 1'b1, 1'b1, 4'd0, 4'd6); s.flush = 1'b1;
    applyStimulus(s, "flush");
    checkOutput("flush_enable", 64'(rs2alu_enable), 64'd0);
    for (int i = 0; i < 3; i++) applyStimulus(idleStim(1'b1), "flush_after");

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) applyStimulus(randStim(), "rand");
    for (int i = 0; i < NE + 2; i++) applyStimulus(idleStim(1'b1), "rand_drain");
    checkOutput("pending_issues", 64'(expQ.size()), 64'd0);
    s = idleStim(1'b0); s.flush = 1'b1;
    applyStimulus(s, "rand_flush");

    $display("[TB] asynchronous reset while an issue is on the port");
    applyStimulus(allocStim(1'b0, 1'b1, 1'b1, 4'd0, 4'd10), "mid_alloc");
    applyStimulus(idleStim(1'b1), "mid_issue");
    checkOutput("mid_enable_before", 64'(rs2alu_enable), 64'd1);
    #1;
    rst_in = 1'b1;
    modelReset();
    #1;
    checkOutput("mid_enable", 64'(rs2alu_enable), 64'd0);
    checkOutput("mid_rs1", 64'(rs2alu_rs1), 64'd0);
    checkOutput("mid_rs2", 64'(rs2alu_rs2), 64'd0);
    checkOutput("mid_imm", 64'(rs2alu_imm), 64'd0);
    checkOutput("mid_pc", 64'(rs2alu_pc), 64'd0);
    checkOutput("mid_type", 64'(rs2alu_ins_type), 64'd0);
    checkOutput("mid_reorder", 64'(rs2alu_reorder), 64'd0);
    checkOutput("mid_full", 64'(rs_full), 64'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    applyStimulus(idleStim(1'b1), "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
